// File: rtl/i2c_temp_sensor_responder.sv
// I2C target emulating the board temperature sensor: answers a read at I2C_ADDR with a
// 16-bit snapshot of temp_word_i, MSB byte first, wrapping while the controller keeps ACKing.
//
// state     | meaning
// IDLE      | bus free, waiting for START
// ADDR      | shifting in the 8-bit address byte
// ADDR_ACK  | driving the address ACK low
// TX_BYTE   | shifting a data byte out on SDA
// RX_ACK    | SDA released, sampling the controller ACK/NACK
// WAIT_STOP | ignoring the bus until START or STOP
module i2c_temp_sensor_responder #(
  parameter logic [6:0] I2C_ADDR    = 7'h4B,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        scl_i,
  inout  wire         sda_io,
  input  logic [15:0] temp_word_i,
  output logic        busy_o,
  output logic        read_done_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, TX_BYTE, RX_ACK, WAIT_STOP
  } state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic        scl_prev_q, sda_prev_q;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  tx_q, tx_d;
  logic [15:0] snap_q, snap_d;
  logic        byte_sel_q, byte_sel_d;
  logic        ack_q, ack_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        read_done_q, read_done_d;

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, addr_match;
  logic [7:0] next_byte;

  // Sync chains reset to 1 (idle bus) so reset release cannot fake a START
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_io};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_prev_q;
  assign scl_fall   = ~scl_s & scl_prev_q;
  assign start_det  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign addr_match = (addr_q[7:1] == I2C_ADDR) && addr_q[0];
  assign next_byte  = byte_sel_q ? snap_q[15:8] : snap_q[7:0];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      addr_q      <= '0;
      tx_q        <= '0;
      snap_q      <= '0;
      byte_sel_q  <= 1'b0;
      ack_q       <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      read_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_q      <= addr_d;
      tx_q        <= tx_d;
      snap_q      <= snap_d;
      byte_sel_q  <= byte_sel_d;
      ack_q       <= ack_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      read_done_q <= read_done_d;
    end
  end

  // START is decoded ahead of STOP
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    snap_d     = snap_q;
    byte_sel_d = byte_sel_q;
    ack_d      = ack_q;
    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
    end else if (stop_det) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            addr_d    = {addr_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (addr_match) begin
              state_d    = ADDR_ACK;
              snap_d     = temp_word_i;
              byte_sel_d = 1'b0;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            state_d   = TX_BYTE;
            tx_d      = {snap_q[14:8], 1'b0};
            bit_cnt_d = 4'd1;
          end
        end
        TX_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d = RX_ACK;
              ack_d   = 1'b0;
            end else begin
              tx_d      = {tx_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        RX_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_d = WAIT_STOP;
            else       ack_d   = 1'b1;
          end else if (scl_fall && ack_q) begin
            state_d    = TX_BYTE;
            byte_sel_d = ~byte_sel_q;
            tx_d       = {next_byte[6:0], 1'b0};
            bit_cnt_d  = 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    read_done_d = 1'b0;
    if (start_det || stop_det) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_fall && bit_cnt_q == 4'd8 && addr_match) begin
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
          end
        end
        ADDR_ACK: if (scl_fall) sda_oe_d = ~snap_q[15];
        TX_BYTE:  if (scl_fall) sda_oe_d = (bit_cnt_q == 4'd8) ? 1'b0 : ~tx_q[7];
        RX_ACK: begin
          if (scl_rise && sda_s) read_done_d = byte_sel_q;
          else if (scl_fall && ack_q) sda_oe_d = ~next_byte[7];
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  // Open-drain: only ever pull low, and let go the instant reset asserts
  assign sda_io      = (sda_oe_q && rst_n_i) ? 1'b0 : 1'bz;
  assign busy_o      = busy_q;
  assign read_done_o = read_done_q;

endmodule

// File: tb/tb_i2c_temp_sensor_responder.sv
// Directed bench: a bit-banged I2C controller reads the emulated sensor through an open-drain bus.
module tb_i2c_temp_sensor_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_sda_low = 1'b0;
  logic [15:0] temp_word = 16'h1A80;
  logic        busy, read_done;
  wire         sda;

  int total = 0;
  int bad = 0;
  int rd_total = 0;
  int rd_base;
  logic [7:0] b;
  logic       ab;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;
  always @(posedge clk) if (read_done) rd_total++;

  i2c_temp_sensor_responder #(.I2C_ADDR(7'h4B), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .scl_i(scl), .sda_io(sda),
    .temp_word_i(temp_word), .busy_o(busy), .read_done_o(read_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wait_clk(5);
    scl = 1'b1;       wait_clk(10);
    m_sda_low = 1'b1; wait_clk(10);
    scl = 1'b0;       wait_clk(5);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wait_clk(5);
    scl = 1'b1;       wait_clk(10);
    m_sda_low = 1'b0; wait_clk(10);
  endtask

  task automatic write_bit(input logic v);
    m_sda_low = ~v; wait_clk(5);
    scl = 1'b1;     wait_clk(10);
    scl = 1'b0;     wait_clk(5);
  endtask

  task automatic read_bit(output logic v);
    m_sda_low = 1'b0; wait_clk(5);
    scl = 1'b1;       wait_clk(5);
    v = sda;          wait_clk(5);
    scl = 1'b0;       wait_clk(5);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_bit);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack_bit);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(v);
      d[i] = v;
    end
    write_bit(~ack);
    m_sda_low = 1'b0;
  endtask

  initial begin
    wait_clk(3);
    check("reset_sda", sda, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done", read_done, 1'b0);
    rst_n = 1'b1;
    wait_clk(5);

    // 1: basic 2-byte read
    rd_base = rd_total;
    i2c_start();
    write_byte(8'h97, ab);
    check("t1_addr_ack", ab, 1'b0);
    check("t1_busy", busy, 1'b1);
    read_byte(b, 1'b1);  check("t1_msb", b, 8'h1A);
    read_byte(b, 1'b0);  check("t1_lsb", b, 8'h80);
    check("t1_busy_before_stop", busy, 1'b1);
    i2c_stop();
    check("t1_busy_after_stop", busy, 1'b0);
    check("t1_done_cnt", rd_total - rd_base, 1);

    // 2: other address, read
    rd_base = rd_total;
    i2c_start();
    write_byte(8'h95, ab);
    check("t2_addr_nack", ab, 1'b1);
    check("t2_busy", busy, 1'b0);
    read_byte(b, 1'b0);  check("t2_data_released", b, 8'hFF);
    i2c_stop();
    check("t2_done_cnt", rd_total - rd_base, 0);

    // 3: write to our address is refused, bus then ignored
    i2c_start();
    write_byte(8'h96, ab);
    check("t3_addr_nack", ab, 1'b1);
    check("t3_busy", busy, 1'b0);
    read_byte(b, 1'b0);  check("t3_wait_stop", b, 8'hFF);
    i2c_stop();

    // 4: snapshot survives TEMP_WORD change
    temp_word = 16'h1A80;
    i2c_start();
    write_byte(8'h97, ab);
    check("t4_addr_ack", ab, 1'b0);
    temp_word = 16'h0000;
    read_byte(b, 1'b1);  check("t4_msb", b, 8'h1A);
    read_byte(b, 1'b0);  check("t4_lsb", b, 8'h80);
    i2c_stop();

    // 5: continuous read wraps
    temp_word = 16'h1A80;
    rd_base = rd_total;
    i2c_start();
    write_byte(8'h97, ab);
    check("t5_addr_ack", ab, 1'b0);
    read_byte(b, 1'b1);  check("t5_b0", b, 8'h1A);
    read_byte(b, 1'b1);  check("t5_b1", b, 8'h80);
    check("t5_no_done_on_ack", rd_total - rd_base, 0);
    read_byte(b, 1'b1);  check("t5_b2", b, 8'h1A);
    read_byte(b, 1'b0);  check("t5_b3", b, 8'h80);
    check("t5_done_cnt", rd_total - rd_base, 1);
    i2c_stop();
    check("t5_done_cnt_end", rd_total - rd_base, 1);

    // 6: reset while DUT drives a 0 bit (0x25 bit3 = 0)
    temp_word = 16'h25C3;
    i2c_start();
    write_byte(8'h97, ab);
    check("t6_addr_ack", ab, 1'b0);
    for (int i = 7; i >= 4; i--) begin
      read_bit(ab);
      check("t6_msb_hi_bits", ab, (i == 5) ? 1'b1 : 1'b0);
    end
    check("t6_bit3_driven", sda, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_sda_released", sda, 1'b1);
    check("t6_busy_reset", busy, 1'b0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);
    i2c_stop();
    rd_base = rd_total;
    i2c_start();
    write_byte(8'h97, ab);
    check("t6_re_ack", ab, 1'b0);
    read_byte(b, 1'b1);  check("t6_re_msb", b, 8'h25);
    read_byte(b, 1'b0);  check("t6_re_lsb", b, 8'hC3);
    i2c_stop();
    check("t6_re_done", rd_total - rd_base, 1);

    // 6b: repeated START during LSB (LSB bit7 = 1 leaves SDA free)
    temp_word = 16'h1A80;
    rd_base = rd_total;
    i2c_start();
    write_byte(8'h97, ab);
    read_byte(b, 1'b1);  check("t6b_msb", b, 8'h1A);
    i2c_start();
    check("t6b_busy_cleared", busy, 1'b0);
    write_byte(8'h97, ab);
    check("t6b_addr_ack", ab, 1'b0);
    read_byte(b, 1'b1);  check("t6b_msb2", b, 8'h1A);
    read_byte(b, 1'b0);  check("t6b_lsb2", b, 8'h80);
    i2c_stop();
    check("t6b_done_cnt", rd_total - rd_base, 1);
    check("t6b_busy_end", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
